// File: rtl/jtframe_lfbuf_pkg.sv
// rtl/jtframe_lfbuf_pkg.sv - shared constants and helpers for the line-frame-buffer scan stage
package jtframe_lfbuf_pkg;

    typedef enum logic {
        BLANK  = 1'b0,
        ACTIVE = 1'b1
    } lfbuf_state_t;

    localparam int CNT_W = 8;

    localparam logic [1:0] ST_CTRL = 2'd0;
    localparam logic [1:0] ST_URUN = 2'd1;
    localparam logic [1:0] ST_OVR  = 2'd2;
    localparam logic [1:0] ST_HCNT = 2'd3;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/jtframe_lfbuf_dpram.sv
// rtl/jtframe_lfbuf_dpram.sv - simple dual-port RAM, synchronous write, registered 1-clk read
module jtframe_lfbuf_dpram #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/jtframe_lfbuf_scan.sv
// rtl/jtframe_lfbuf_scan.sv - ping-pong line RAM replay with under/overrun status; JTFRAME_LFBUF_CLR_EN clears pixels after display
module jtframe_lfbuf_scan
    import jtframe_lfbuf_pkg::*;
#(
    parameter int HW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          lhbl,
    input  logic          lvbl,
    input  logic          scr_we,
    input  logic [HW-1:0] rd_addr,
    input  logic [DW-1:0] fb_dout,
    output logic [DW-1:0] pxl_dout,
    output logic          pxl_lhbl,
    output logic          underrun,
    input  logic [7:0]    st_addr,
    output logic [7:0]    st_dout
);

    lfbuf_state_t     state, state_nx;
    logic             dbank, full, we_l, rd_vld;
    logic [HW-1:0]    hcnt;
    logic [CNT_W-1:0] urun_cnt, ovr_cnt;
    logic             we_rise, we_fall, lhbl_rise;
    logic             start, swap, urun, rd_en;
    logic             ram_we;
    logic [HW:0]      ram_waddr, rd_ptr;
    logic [DW-1:0]    ram_wdata, ram_q;
    logic             unused_st;

    assign unused_st = ^st_addr[7:2];
    assign we_rise   = scr_we & ~we_l;
    assign we_fall   = ~scr_we & we_l;
    // pxl_lhbl doubles as the previous pixel-sampled lhbl for edge detection
    assign lhbl_rise = pxl_cen & lhbl & ~pxl_lhbl;
    assign rd_ptr    = {dbank, hcnt};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= BLANK;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            BLANK:  if (lhbl_rise && lvbl) state_nx = ACTIVE;
            ACTIVE: if (pxl_cen && !lhbl)  state_nx = BLANK;
            default: state_nx = BLANK;
        endcase
    end

    // a burst ending in the same clk as the line start still counts as complete
    always_comb begin
        start = (state == BLANK) && lhbl_rise && lvbl;
        swap  = start && (full || we_fall);
        urun  = start && !(full || we_fall);
        rd_en = (state == ACTIVE) && pxl_cen && lhbl;
    end

`ifdef JTFRAME_LFBUF_CLR_EN
    logic        clr_req, clr_pend;
    logic [HW:0] clr_addr, clr_pend_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_req       <= 1'b0;
            clr_pend      <= 1'b0;
            clr_addr      <= '0;
            clr_pend_addr <= '0;
        end else begin
            clr_req <= rd_en;
            if (rd_en) clr_addr <= rd_ptr;
            if (clr_req && (scr_we || clr_pend)) begin
                clr_pend      <= 1'b1;
                clr_pend_addr <= clr_addr;
            end else if (clr_pend && !scr_we) begin
                clr_pend <= 1'b0;
            end
        end
    end

    // burst writes own the port; clears wait for an idle clk
    always_comb begin
        ram_we    = scr_we;
        ram_waddr = {~dbank, rd_addr};
        ram_wdata = fb_dout;
        if (!scr_we) begin
            if (clr_pend) begin
                ram_we    = 1'b1;
                ram_waddr = clr_pend_addr;
                ram_wdata = '0;
            end else if (clr_req) begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr;
                ram_wdata = '0;
            end
        end
    end
`else
    always_comb begin
        ram_we    = scr_we;
        ram_waddr = {~dbank, rd_addr};
        ram_wdata = fb_dout;
    end
`endif

    jtframe_lfbuf_dpram #(.AW(HW+1), .DW(DW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_en),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbank    <= 1'b0;
            full     <= 1'b0;
            we_l     <= 1'b0;
            hcnt     <= '0;
            urun_cnt <= '0;
            ovr_cnt  <= '0;
            pxl_dout <= '0;
            pxl_lhbl <= 1'b0;
            underrun <= 1'b0;
            rd_vld   <= 1'b0;
            st_dout  <= '0;
        end else begin
            we_l     <= scr_we;
            underrun <= urun;
            if (swap) begin
                dbank <= ~dbank;
                full  <= 1'b0;
            end else if (we_fall) begin
                full <= 1'b1;
            end
            if (urun)            urun_cnt <= sat_inc(urun_cnt);
            if (we_rise && full) ovr_cnt  <= sat_inc(ovr_cnt);
            if (start)                hcnt <= '0;
            else if (rd_en && !(&hcnt)) hcnt <= hcnt + HW'(1);
            if (pxl_cen) begin
                pxl_lhbl <= lhbl;
                rd_vld   <= rd_en;
`ifdef JTFRAME_LFBUF_CLR_EN
                pxl_dout <= rd_vld ? ram_q : '0;
`else
                if (rd_vld) pxl_dout <= ram_q;
`endif
            end
            case (st_addr[1:0])
                ST_CTRL: st_dout <= {dbank, full, 5'd0, state == ACTIVE};
                ST_URUN: st_dout <= urun_cnt;
                ST_OVR:  st_dout <= ovr_cnt;
                ST_HCNT: st_dout <= hcnt[7:0];
                default: st_dout <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_lfbuf_scan.sv
// tb/tb_jtframe_lfbuf_scan.sv - scoreboard bench for jtframe_lfbuf_scan against a bank-level line model
module tb_jtframe_lfbuf_scan;

    logic        clk = 1'b0;
    logic        rst_n, pxl_cen, lhbl, lvbl, scr_we;
    logic [8:0]  rd_addr;
    logic [15:0] fb_dout, pxl_dout;
    logic        pxl_lhbl, underrun;
    logic [7:0]  st_addr, st_dout;

    always #5 clk = ~clk;

    jtframe_lfbuf_scan #(.HW(9), .DW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .lhbl     (lhbl),
        .lvbl     (lvbl),
        .scr_we   (scr_we),
        .rd_addr  (rd_addr),
        .fb_dout  (fb_dout),
        .pxl_dout (pxl_dout),
        .pxl_lhbl (pxl_lhbl),
        .underrun (underrun),
        .st_addr  (st_addr),
        .st_dout  (st_dout)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem [2][512];
    logic [15:0] exp_q [$];
    bit          db_m, full_m;
    int          urun_m, ovr_m, hcnt_m, exp_pulses, pulses_seen;
    bit          cen_q, h1, h2;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix();
        pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        tick();
    endtask

    task automatic chk_st(input logic [1:0] a, input logic [7:0] exp, input string nm);
        st_addr = {6'd0, a};
        tick();
        tick();
        check(nm, st_dout, exp);
    endtask

    task automatic chk_all(input string tag);
        chk_st(2'd0, {db_m, full_m, 6'd0}, {tag, "_ctrl"});
        chk_st(2'd1, urun_m[7:0], {tag, "_urun"});
        chk_st(2'd2, ovr_m[7:0], {tag, "_ovr"});
        chk_st(2'd3, hcnt_m[7:0], {tag, "_hcnt"});
    endtask

    // one line burst into the bank not on screen; keep leaves scr_we high for a bypass start
    task automatic burst(input int n, input bit rnd, input bit keep);
        logic [15:0] d;
        if (full_m) ovr_m = (ovr_m < 255) ? ovr_m + 1 : 255;
        for (int i = 0; i < n; i++) begin
            d       = rnd ? 16'($urandom) : (16'(i) ^ 16'hA5A5);
            scr_we  = 1'b1;
            rd_addr = 9'(i);
            fb_dout = d;
            mem[db_m ^ 1'b1][i] = d;
            tick();
        end
        if (!keep) begin
            scr_we = 1'b0;
            tick();
            full_m = 1'b1;
        end
    endtask

    task automatic display(input int n, input bit bypass, input bit vb, input string tag);
        int a;
        if (bypass) full_m = 1'b1;
        if (!vb) begin
            if (full_m) begin
                db_m   = ~db_m;
                full_m = 1'b0;
            end else begin
                urun_m = (urun_m < 255) ? urun_m + 1 : 255;
                exp_pulses++;
            end
            for (int j = 0; j < n; j++) begin
                a = (j > 511) ? 511 : j;
                exp_q.push_back(mem[db_m][a]);
`ifdef JTFRAME_LFBUF_CLR_EN
                mem[db_m][a] = 16'h0;
`endif
            end
            hcnt_m = (n > 511) ? 511 : n;
        end
        lvbl = !vb;
        lhbl = 1'b1;
        if (bypass) scr_we = 1'b0;
        pix();
        if (!vb) chk_st(2'd0, {db_m, 1'b0, 5'd0, 1'b1}, {tag, "_active"});
        repeat (n) pix();
        lhbl = 1'b0;
        repeat (3) pix();
        chk_all(tag);
    endtask

    always @(posedge clk) cen_q <= pxl_cen;

    // a pixel is on pxl_dout after every pixel tick whose two predecessors had pxl_lhbl high
    always @(negedge clk) begin
        if (underrun) pulses_seen++;
        if (!rst_n) begin
            h1 = 1'b0;
            h2 = 1'b0;
        end else if (cen_q) begin
            if (h1 && h2 && exp_q.size() > 0) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("pixel", pxl_dout, e);
            end
            h2 = h1;
            h1 = pxl_lhbl;
        end
    end

    initial begin
        rst_n = 1'b0; pxl_cen = 1'b0; lhbl = 1'b0; lvbl = 1'b0; scr_we = 1'b0;
        rd_addr = '0; fb_dout = '0; st_addr = '0;
        db_m = 1'b0; full_m = 1'b0; urun_m = 0; ovr_m = 0; hcnt_m = 0;
        exp_pulses = 0; pulses_seen = 0;
        repeat (3) tick();
        check("rst_pxl_dout", pxl_dout, 16'h0);
        check("rst_pxl_lhbl", pxl_lhbl, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_st_dout", st_dout, 8'h0);
        rst_n = 1'b1;
        tick();
        chk_all("reset");

        for (int i = 0; i < 10; i++) display(3, 1'b0, 1'b1, "vblank");

        burst(512, 1'b0, 1'b0);
        chk_all("burst1");
        display(520, 1'b0, 1'b0, "line1");

        display(25, 1'b0, 1'b0, "underrun");

        burst(512, 1'b1, 1'b0);
        burst(512, 1'b1, 1'b0);
        chk_all("overrun");
        display(40, 1'b0, 1'b0, "overrun_show");

        burst(512, 1'b1, 1'b1);
        display(30, 1'b1, 1'b0, "bypass");

        for (int k = 0; k < 14; k++) begin
            case ($urandom_range(0, 3))
                0: burst(512, 1'b1, 1'b0);
                1: display($urandom_range(1, 40), 1'b0, 1'b0, "rnd_line");
                2: begin
                    burst(512, 1'b1, 1'b1);
                    display($urandom_range(1, 40), 1'b1, 1'b0, "rnd_bypass");
                end
                default: display($urandom_range(1, 8), 1'b0, 1'b1, "rnd_vblank");
            endcase
        end

        for (int i = 0; i < 260; i++) display(1, 1'b0, 1'b0, "urun_sat");
        check("urun_saturated", urun_m, 255);

        burst(100, 1'b1, 1'b1);
        rst_n  = 1'b0;
        scr_we = 1'b0;
        tick();
        check("midrst_pxl_dout", pxl_dout, 16'h0);
        check("midrst_underrun", underrun, 1'b0);
        rst_n = 1'b1;
        db_m = 1'b0; full_m = 1'b0; urun_m = 0; ovr_m = 0; hcnt_m = 0;
        tick();
        chk_all("after_rst");
        burst(512, 1'b0, 1'b0);
        display(30, 1'b0, 1'b0, "post_rst");

        repeat (6) tick();
        check("queue_drained", exp_q.size(), 0);
        check("underrun_pulses", pulses_seen, exp_pulses);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
